// File: rtl/axil_register_initiator_if.sv
// Command/response channel plus AXI4-Lite master bus for axil_register_initiator.
// The master modport is the initiator's view; slave is the sequencer/peripheral side.
interface axil_register_initiator_if #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 11
);
  localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata;
  logic [StrbW-1:0]              cmd_wstrb;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_write;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]                    rsp_resp;

  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]                    M_AXI_AWPROT;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [StrbW-1:0]              M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY
  );
endinterface

// File: rtl/axil_register_initiator.sv
// AXI4-Lite master turning single register commands into one outstanding read or write,
// returning the slave's response on a valid/ready channel. All outputs are registered.
module axil_register_initiator #(
  parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 11,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR         = '0
) (
  input logic                       M_AXI_ACLK,
  input logic                       M_AXI_ARESETN,
  axil_register_initiator_if.master bus
);
  localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } state_e;

  state_e                        state_q, state_d;
  logic                          cmd_ready_q, cmd_ready_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          rsp_write_q, rsp_write_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]              wstrb_q, wstrb_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = bus.cmd_addr | BASE_ADDR;
          if (bus.cmd_write) begin
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        // AW and W retire independently; B is only opened once both are done.
        if (bus.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (bus.M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (bus.M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bus.M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end
      end
      StRdReq: begin
        if (bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdResp;
        end
      end
      StRdResp: begin
        if (bus.M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = bus.M_AXI_RDATA;
          rsp_resp_d  = bus.M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Only one transaction is ever in flight, so AW and AR share the address register.
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;
  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_resp      = rsp_resp_q;
endmodule

// File: tb/tb_axil_register_initiator.sv
// Bench for axil_register_initiator: directed commands against a latency-programmable
// slave model, with expected responses and bus beats scoreboarded by negedge monitors.
module tb_axil_register_initiator;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_register_initiator_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();
  axil_register_initiator_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus_b ();

  axil_register_initiator #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .BASE_ADDR         (11'h000)
  ) u_dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  axil_register_initiator #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .BASE_ADDR         (11'h400)
  ) u_dut_b (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus_b)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [10:0] aw_q[$];
  logic [10:0] ar_q[$];
  logic [35:0] w_q[$];
  rsp_t        mon_e;

  int n_pass  = 0;
  int n_total = 0;

  // Slave model configuration.
  int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  b_resp = 2'b00;
  logic [1:0]  r_resp = 2'b00;
  logic [31:0] r_data = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Slave: each READY/VALID rises after its programmed number of waiting cycles.
  initial begin : slave
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b11;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RDATA   = 32'hBAD0_BAD0;
    bus.M_AXI_RRESP   = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      if (bus.M_AXI_AWVALID) begin
        bus.M_AXI_AWREADY = (aw_cnt == aw_lat); aw_cnt++;
      end else begin
        bus.M_AXI_AWREADY = 1'b0; aw_cnt = 0;
      end
      if (bus.M_AXI_WVALID) begin
        bus.M_AXI_WREADY = (w_cnt == w_lat); w_cnt++;
      end else begin
        bus.M_AXI_WREADY = 1'b0; w_cnt = 0;
      end
      if (bus.M_AXI_ARVALID) begin
        bus.M_AXI_ARREADY = (ar_cnt == ar_lat); ar_cnt++;
      end else begin
        bus.M_AXI_ARREADY = 1'b0; ar_cnt = 0;
      end
      if (bus.M_AXI_BREADY) begin
        bus.M_AXI_BVALID = (b_cnt == b_lat); b_cnt++;
      end else begin
        bus.M_AXI_BVALID = 1'b0; b_cnt = 0;
      end
      bus.M_AXI_BRESP = bus.M_AXI_BVALID ? b_resp : 2'b11;
      if (bus.M_AXI_RREADY) begin
        bus.M_AXI_RVALID = (r_cnt == r_lat); r_cnt++;
      end else begin
        bus.M_AXI_RVALID = 1'b0; r_cnt = 0;
      end
      bus.M_AXI_RDATA = bus.M_AXI_RVALID ? r_data : 32'hBAD0_BAD0;
      bus.M_AXI_RRESP = bus.M_AXI_RVALID ? r_resp : 2'b11;
    end
  end

  // Monitors: compare every completed handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_write", bus.rsp_write, mon_e.wr);
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_resp", bus.rsp_resp, mon_e.resp);
      end
    end
    if (rst_n && bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
      chk("aw_expected", aw_q.size() != 0, 1'b1);
      if (aw_q.size() != 0) chk("awaddr", bus.M_AXI_AWADDR, aw_q.pop_front());
    end
    if (rst_n && bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
      chk("w_expected", w_q.size() != 0, 1'b1);
      if (w_q.size() != 0) chk("wstrb_wdata", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, w_q.pop_front());
    end
    if (rst_n && bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
      chk("ar_expected", ar_q.size() != 0, 1'b1);
      if (ar_q.size() != 0) chk("araddr", bus.M_AXI_ARADDR, ar_q.pop_front());
    end
  end

  // Returns #1 after the accepting edge, i.e. inside cycle N+1.
  task automatic send(input logic wr, input logic [10:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rdata,
                      input logic [1:0] exp_resp);
    int n = 0;
    rsp_t e;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
    e.wr    = wr;
    e.rdata = exp_rdata;
    e.resp  = exp_resp;
    exp_q.push_back(e);
    if (wr) begin
      aw_q.push_back(addr);
      w_q.push_back({strb, data});
    end else begin
      ar_q.push_back(addr);
    end
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.cmd_ready, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    int k;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b1;

    bus_b.cmd_valid     = 1'b0;
    bus_b.cmd_write     = 1'b0;
    bus_b.cmd_addr      = '0;
    bus_b.cmd_wdata     = '0;
    bus_b.cmd_wstrb     = '0;
    bus_b.rsp_ready     = 1'b1;
    bus_b.M_AXI_AWREADY = 1'b1;
    bus_b.M_AXI_WREADY  = 1'b1;
    bus_b.M_AXI_BVALID  = 1'b1;
    bus_b.M_AXI_BRESP   = 2'b00;
    bus_b.M_AXI_ARREADY = 1'b1;
    bus_b.M_AXI_RVALID  = 1'b1;
    bus_b.M_AXI_RDATA   = 32'h0000_0077;
    bus_b.M_AXI_RRESP   = 2'b00;

    // Reset state
    #12;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                       bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.rsp_valid}, 6'b0);
    chk("rst_addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 22'h0);
    chk("rst_wdata", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, 36'h0);
    chk("rst_rsp", {bus.rsp_write, bus.rsp_rdata, bus.rsp_resp}, 35'h0);
    chk("rst_prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 6'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: zero-wait write, cycle-exact latency
    send(1'b1, 11'h004, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00);
    @(negedge clk);
    chk("t1_awvalid_n1", bus.M_AXI_AWVALID, 1'b1);
    chk("t1_wvalid_n1", bus.M_AXI_WVALID, 1'b1);
    chk("t1_awaddr_n1", bus.M_AXI_AWADDR, 11'h004);
    chk("t1_wdata_n1", bus.M_AXI_WDATA, 32'hDEAD_BEEF);
    chk("t1_cmd_ready_n1", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("t1_bready_n2", bus.M_AXI_BREADY, 1'b1);
    chk("t1_awvalid_n2", bus.M_AXI_AWVALID, 1'b0);
    chk("t1_rsp_valid_n2", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("t1_rsp_valid_n3", bus.rsp_valid, 1'b1);
    wait_idle("t1_idle");

    // 2: read with RVALID delayed 5 cycles
    r_lat  = 5;
    r_data = 32'h0000_00A5;
    r_resp = 2'b00;
    send(1'b0, 11'h008, 32'h0, 4'h0, 32'h0000_00A5, 2'b00);
    @(negedge clk);
    chk("t2_arvalid_n1", bus.M_AXI_ARVALID, 1'b1);
    n = 0;
    k = 0;
    while (!(bus.M_AXI_RREADY && bus.M_AXI_RVALID) && k < 100) begin
      @(negedge clk);
      if (bus.M_AXI_RREADY && !bus.M_AXI_RVALID) n++;
      k++;
    end
    chk("t2_rready_wait_cycles", n, 5);
    wait_idle("t2_idle");
    r_lat = 0;

    // 3: skewed AW/W handshakes
    aw_lat = 1;
    w_lat  = 4;
    send(1'b1, 11'h00C, 32'h1234_5678, 4'h3, 32'h0, 2'b00);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk("t3_awvalid", bus.M_AXI_AWVALID, c <= 1);
      chk("t3_wvalid", bus.M_AXI_WVALID, c <= 4);
      chk("t3_bready", bus.M_AXI_BREADY, c == 5);
      if (c <= 4) chk("t3_wdata_stable", bus.M_AXI_WDATA, 32'h1234_5678);
    end
    wait_idle("t3_idle");
    aw_lat = 0;
    w_lat  = 0;

    // 4: response backpressure with SLVERR
    b_resp        = 2'b10;
    bus.rsp_ready = 1'b0;
    send(1'b1, 11'h010, 32'h0000_0001, 4'h1, 32'h0, 2'b10);
    k = 0;
    while (!bus.rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 10; c++) begin
      chk("t4_rsp_valid_held", bus.rsp_valid, 1'b1);
      chk("t4_rsp_resp_held", bus.rsp_resp, 2'b10);
      chk("t4_cmd_ready_low", bus.cmd_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_cmd_ready_after", bus.cmd_ready, 1'b1);
    chk("t4_rsp_valid_after", bus.rsp_valid, 1'b0);
    b_resp = 2'b00;

    // 5: asynchronous reset while ARVALID is high, then a clean read
    ar_lat = 20;
    send(1'b0, 11'h014, 32'h0, 4'h0, 32'h0, 2'b00);
    @(negedge clk);
    chk("t5_arvalid_pre", bus.M_AXI_ARVALID, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arvalid_rst", bus.M_AXI_ARVALID, 1'b0);
    chk("t5_cmd_ready_rst", bus.cmd_ready, 1'b1);
    exp_q.delete();
    ar_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    ar_lat = 0;
    r_data = 32'h5A5A_0001;
    send(1'b0, 11'h018, 32'h0, 4'h0, 32'h5A5A_0001, 2'b00);
    wait_idle("t5_idle");

    // 6: DECERR read passes through untouched
    r_data = 32'hCAFE_F00D;
    r_resp = 2'b11;
    send(1'b0, 11'h01C, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b11);
    wait_idle("t6_idle");
    r_resp = 2'b00;

    // 7: BASE_ADDR is OR'd into the issued address
    @(posedge clk);
    #1;
    bus_b.cmd_valid = 1'b1;
    bus_b.cmd_write = 1'b0;
    bus_b.cmd_addr  = 11'h010;
    @(negedge clk);
    chk("t7_cmd_ready", bus_b.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus_b.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t7_arvalid", bus_b.M_AXI_ARVALID, 1'b1);
    chk("t7_araddr", bus_b.M_AXI_ARADDR, 11'h410);
    @(negedge clk);
    chk("t7_rready", bus_b.M_AXI_RREADY, 1'b1);
    @(negedge clk);
    chk("t7_rsp_valid", bus_b.rsp_valid, 1'b1);
    chk("t7_rsp_rdata", bus_b.rsp_rdata, 32'h0000_0077);

    @(negedge clk);
    chk("sb_rsp_drained", exp_q.size(), 0);
    chk("sb_aw_drained", aw_q.size(), 0);
    chk("sb_w_drained", w_q.size(), 0);
    chk("sb_ar_drained", ar_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axil_register_initiator.md
Name: axil_register_initiator

Overview:
- AXI4-Lite master that turns single-beat register commands into AXI4-Lite read or write transactions.
- Sits between an on-fabric sequencer or test engine and any AXI4-Lite register slave in the platform, such as the clock divider.
- Lets hardware program peripheral registers without the processor.
- Exactly one transaction is outstanding at a time; the response is returned through a valid/ready channel.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data bus width (32 or 64).
- C_M_AXI_ADDR_WIDTH, 11, address bus width.
- BASE_ADDR, 0, constant OR'd into every issued address.

Ports:
- M_AXI_ACLK  in  1  single clock for all logic.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_resp  out  2  BRESP or RRESP.
- M_AXI_AWADDR  out  ADDR_W;  M_AXI_AWPROT  out  3;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DATA_W;  M_AXI_WSTRB  out  DATA_W/8;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_W;  M_AXI_ARPROT  out  3;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA_W;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1

Behaviour:
- Clock and reset: one clock, M_AXI_ACLK. Reset M_AXI_ARESETN is asynchronous, active-low. All outputs are registered.
- Reset values:
  - all *VALID, BREADY, RREADY, rsp_valid = 0; cmd_ready = 1.
  - addresses, data, strobes, rsp_rdata, rsp_resp, rsp_write = 0.
  - AWPROT and ARPROT are tied to 3'b000.
- Reset mid-transaction: return to IDLE immediately and drop every valid. The system resets the slave on the same reset, so this is protocol-legal.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, capture command with address = cmd_addr | BASE_ADDR; cmd_ready drops next cycle.
  - Write command: AWVALID and WVALID assert together next cycle; go to WR_REQ.
  - Read command: ARVALID asserts next cycle; go to RD_REQ.
- WR_REQ:
  - AW and W handshakes complete independently; each VALID drops the cycle after its own READY is sampled high.
  - Address and data stay stable while VALID is high.
  - Once both have completed (same cycle or different cycles), BREADY = 1 next cycle; go to WR_RESP.
  - BVALID arriving before both handshakes finish is not accepted; BREADY stays 0 until then.
- WR_RESP:
  - On BVALID & BREADY, latch BRESP and set rsp_write = 1, rsp_rdata = 0.
  - BREADY drops; go to RSP.
- RD_REQ: on ARREADY, ARVALID drops; RREADY = 1 next cycle; go to RD_RESP.
- RD_RESP:
  - On RVALID & RREADY, latch RDATA and RRESP, set rsp_write = 0.
  - RREADY drops; go to RSP.
- RSP:
  - rsp_valid = 1; all response fields stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, rsp_valid drops; go to IDLE. cmd_ready is 1 in the following cycle, with no back-to-back bypass.
- Minimum latency with zero-wait slave: cmd accept in cycle N.
  - Write: AW/W valid in N+1, BREADY in N+2, BVALID sampled N+2, rsp_valid N+3.
  - Read: same timing, with ARVALID N+1 and RVALID sampled N+2.
- SLVERR/DECERR responses are passed through unmodified; no retry.
- No timeout. A hung slave holds the FSM in its current state until reset.

Test Plan:
- Write, zero-wait slave: cmd addr=0x004, data=0xDEADBEEF, strb=0xF -> AWADDR=0x004 and WDATA=0xDEADBEEF in cycle N+1; rsp_valid in N+3 with rsp_write=1, rsp_resp=0.
- Read, RVALID delayed 5 cycles, RDATA=0x0000_00A5 -> RREADY held high 5 cycles; rsp_rdata=0xA5, rsp_write=0, rsp_resp=0.
- Skewed write channels: AWREADY at +1, WREADY at +4 -> AWVALID drops after +1, WVALID stays high with stable data until +4, and BREADY=0 until then.
- Response backpressure and error: rsp_ready held low 10 cycles, BRESP=2'b10 -> rsp_valid and rsp_resp=2 stable all 10 cycles; cmd_ready=0 throughout; cmd_ready=1 the cycle after rsp_ready.
- Reset mid-read: assert M_AXI_ARESETN low while ARVALID=1 -> ARVALID=0 and cmd_ready=1 asynchronously; after release, the next read completes normally.
- BASE_ADDR=0x400, cmd addr=0x010 read -> ARADDR=0x410.
